// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access sizes, FSM states and error causes for the load/store unit
package lsu_pkg;
  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_MISALIGN, CAUSE_SIZE, CAUSE_TIMEOUT} lsu_cause_t;
  function automatic logic size_legal(input logic [2:0] s);
    return s inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: word-wide data-memory port between the load/store unit and the memory
interface lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  modport master(output req, we, be, addr, wd, input rd, ready);
  modport slave(input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/lsu_data_align.sv
// lsu_data_align: byte enables, store lane replication, load extension and access checks
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wd,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rd,
  output logic [3:0]  be,
  output logic [31:0] wd_rep,
  output logic [31:0] rd_ext,
  output logic        misalign,
  output logic        illegal
);
  logic [31:0] lane;
  // size[1:0] selects the width for both signed and unsigned encodings
  always_comb begin
    illegal  = !size_legal(size);
    misalign = (size == LDST_W) ? (off != 2'b00) : ((size == LDST_H) || (size == LDST_HU)) && off[0];
    be       = (size[1:0] == 2'd0) ? 4'b0001 << off : (size[1:0] == 2'd1) ? 4'b0011 << off : 4'b1111;
    wd_rep   = (size[1:0] == 2'd0) ? {4{wd[7:0]}} : (size[1:0] == 2'd1) ? {2{wd[15:0]}} : wd;
    lane     = rd >> {ld_off, 3'b000};
    rd_ext   = (ld_size == LDST_B)  ? {{24{lane[7]}}, lane[7:0]} :
               (ld_size == LDST_BU) ? {24'd0, lane[7:0]} :
               (ld_size == LDST_H)  ? {{16{lane[15]}}, lane[15:0]} :
               (ld_size == LDST_HU) ? {16'd0, lane[15:0]} : rd;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences core data accesses onto the memory port with stall, checks and timeout
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_err_o,
  output lsu_cause_t  lsu_cause_o,
  lsu_if.master       mem
);
  lsu_state_t  state;
  logic [31:0] cnt;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] rd_ext;
  logic        misalign;
  logic        illegal;
  lsu_data_align u_align (
    .size    (core_size_i),
    .off     (core_addr_i[1:0]),
    .wd      (core_wd_i),
    .ld_size (size_q),
    .ld_off  (off_q),
    .rd      (mem.rd),
    .be      (be),
    .wd_rep  (wd_rep),
    .rd_ext  (rd_ext),
    .misalign(misalign),
    .illegal (illegal)
  );
  assign core_stall_o = core_req_i & (state != DONE);
  // access FSM: checks in IDLE, waits for ready or timeout in BUSY, releases the core in DONE
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      size_q      <= '0;
      off_q       <= '0;
      core_rd_o   <= '0;
      lsu_err_o   <= 1'b0;
      lsu_cause_o <= CAUSE_NONE;
      mem.req     <= 1'b0;
      mem.we      <= 1'b0;
      mem.be      <= '0;
      mem.addr    <= '0;
      mem.wd      <= '0;
    end else begin
      case (state)
        IDLE: if (core_req_i) begin
          if (illegal || misalign) begin
            state       <= DONE;
            core_rd_o   <= '0;
            lsu_err_o   <= 1'b1;
            lsu_cause_o <= illegal ? CAUSE_SIZE : CAUSE_MISALIGN;
          end else begin
            state    <= BUSY;
            cnt      <= '0;
            size_q   <= core_size_i;
            off_q    <= core_addr_i[1:0];
            mem.req  <= 1'b1;
            mem.we   <= core_we_i;
            mem.be   <= be;
            mem.addr <= {core_addr_i[31:2], 2'b00};
            mem.wd   <= wd_rep;
          end
        end
        BUSY: if (mem.ready) begin
          state       <= DONE;
          mem.req     <= 1'b0;
          core_rd_o   <= mem.we ? 32'd0 : rd_ext;
          lsu_err_o   <= 1'b0;
          lsu_cause_o <= CAUSE_NONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          state       <= DONE;
          mem.req     <= 1'b0;
          core_rd_o   <= '0;
          lsu_err_o   <= 1'b1;
          lsu_cause_o <= CAUSE_TIMEOUT;
        end else begin
          cnt <= cnt + 32'd1;
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          core_rd_o   <= '0;
          lsu_err_o   <= 1'b0;
          lsu_cause_o <= CAUSE_NONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus reset and back-to-back sequences
module tb_load_store_unit;
  import lsu_pkg::*;
  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] maddr;
    logic [31:0] rd;
    int          cause;
    int          stalls;
    logic        req;
  } vec_t;
  logic        clk = 0;
  logic        rst = 1;
  logic        core_req = 0;
  logic        core_we = 0;
  logic [2:0]  core_size = 0;
  logic [31:0] core_addr = 0;
  logic [31:0] core_wd = 0;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        err;
  lsu_cause_t  cause;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[14];
  lsu_if mem();
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .core_req_i  (core_req),
    .core_we_i   (core_we),
    .core_size_i (core_size),
    .core_addr_i (core_addr),
    .core_wd_i   (core_wd),
    .core_rd_o   (core_rd),
    .core_stall_o(core_stall),
    .lsu_err_o   (err),
    .lsu_cause_o (cause),
    .mem         (mem)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    int   stalls = 0;
    int   busy = 0;
    logic seen = 0;
    logic fin = 0;
    core_req = 1; core_we = v.we; core_size = v.size; core_addr = v.addr; core_wd = v.wd;
    mem.rd = v.rdata; mem.ready = 0;
    #1;
    if (!core_stall) begin @(negedge clk); #1; end
    for (int c = 0; c < 40 && !fin; c++) begin
      if (!core_stall) begin
        fin = 1;
        mem.ready = 0;
        chk({nm, " rd"}, core_rd, v.rd);
        chk({nm, " cause"}, 32'(int'(cause)), 32'(v.cause));
        chk({nm, " err"}, 32'(err), 32'(v.cause != 0));
        chk({nm, " done_req"}, 32'(mem.req), 32'd0);
      end else begin
        stalls++;
        if (mem.req) begin
          busy++;
          if (!seen) begin
            seen = 1;
            chk({nm, " be"}, 32'(mem.be), 32'(v.be));
            chk({nm, " wd"}, mem.wd, v.mwd);
            chk({nm, " addr"}, mem.addr, v.maddr);
            chk({nm, " we"}, 32'(mem.we), 32'(v.we));
          end
          mem.ready = busy > v.waits;
        end
        @(negedge clk); #1;
      end
    end
    chk({nm, " finished"}, 32'(fin), 32'd1);
    chk({nm, " stalls"}, 32'(stalls), 32'(v.stalls));
    chk({nm, " mem_req_seen"}, 32'(seen), 32'(v.req));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{1, LDST_W,  32'h100, 32'hDEADBEEF, 32'h0,        0,  4'b1111, 32'hDEADBEEF, 32'h100, 32'h0,        0, 2, 1};
    tbl[1]  = '{1, LDST_B,  32'h103, 32'h123456A5, 32'h0,        0,  4'b1000, 32'hA5A5A5A5, 32'h100, 32'h0,        0, 2, 1};
    tbl[2]  = '{0, LDST_B,  32'h102, 32'h0,        32'h00807F00, 0,  4'b0100, 32'h0,        32'h100, 32'hFFFFFF80, 0, 2, 1};
    tbl[3]  = '{0, LDST_BU, 32'h102, 32'h0,        32'h00807F00, 0,  4'b0100, 32'h0,        32'h100, 32'h00000080, 0, 2, 1};
    tbl[4]  = '{0, LDST_H,  32'h002, 32'h0,        32'h00807F00, 1,  4'b1100, 32'h0,        32'h000, 32'h00000080, 0, 3, 1};
    tbl[5]  = '{0, LDST_H,  32'h000, 32'h0,        32'h1234F00D, 0,  4'b0011, 32'h0,        32'h000, 32'hFFFFF00D, 0, 2, 1};
    tbl[6]  = '{0, LDST_HU, 32'h000, 32'h0,        32'h1234F00D, 2,  4'b0011, 32'h0,        32'h000, 32'h0000F00D, 0, 4, 1};
    tbl[7]  = '{0, LDST_W,  32'h102, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        1, 1, 0};
    tbl[8]  = '{0, 3'd3,    32'h100, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        2, 1, 0};
    tbl[9]  = '{1, LDST_H,  32'h101, 32'hBEEF,     32'h0,        0,  4'b0000, 32'h0,        32'h0,   32'h0,        1, 1, 0};
    tbl[10] = '{1, LDST_H,  32'h106, 32'h0000BEEF, 32'h0,        0,  4'b1100, 32'hBEEFBEEF, 32'h104, 32'h0,        0, 2, 1};
    tbl[11] = '{0, LDST_W,  32'h200, 32'h0,        32'h55555555, 10, 4'b1111, 32'h0,        32'h200, 32'h0,        3, 5, 1};
    tbl[12] = '{0, LDST_W,  32'h204, 32'h0,        32'hCAFEF00D, 3,  4'b1111, 32'h0,        32'h204, 32'hCAFEF00D, 0, 5, 1};
    tbl[13] = '{0, LDST_B,  32'h001, 32'h0,        32'h00007F00, 0,  4'b0010, 32'h0,        32'h000, 32'h0000007F, 0, 2, 1};
    mem.rd = 0; mem.ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset req", 32'(mem.req), 32'd0);
    chk("reset be", 32'(mem.be), 32'd0);
    chk("reset addr", mem.addr, 32'd0);
    chk("reset wd", mem.wd, 32'd0);
    chk("reset rd", core_rd, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset cause", 32'(int'(cause)), 32'd0);
    chk("reset stall", 32'(core_stall), 32'd0);
    for (int i = 0; i < 14; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      core_req = 0;
      @(negedge clk); #1;
      chk($sformatf("vec%0d err_cleared", i), 32'(err), 32'd0);
    end
    core_req = 1; core_we = 0; core_size = LDST_W; core_addr = 32'h300; mem.ready = 0;
    @(negedge clk); #1;
    chk("rstbusy req_before", 32'(mem.req), 32'd1);
    rst = 1; core_req = 0;
    @(negedge clk); #1;
    chk("rstbusy req_after", 32'(mem.req), 32'd0);
    chk("rstbusy err_after", 32'(err), 32'd0);
    chk("rstbusy cause_after", 32'(int'(cause)), 32'd0);
    rst = 0;
    @(negedge clk); #1;
    chk("rstbusy no_done_err", 32'(err), 32'd0);
    chk("rstbusy stays_idle_req", 32'(mem.req), 32'd0);
    run_vec('{1, LDST_W, 32'h10, 32'h11223344, 32'h0, 0, 4'b1111, 32'h11223344, 32'h10, 32'h0, 0, 2, 1}, "b2b_sw");
    run_vec('{0, LDST_W, 32'h10, 32'h0, 32'h11223344, 0, 4'b1111, 32'h0, 32'h10, 32'h11223344, 0, 2, 1}, "b2b_lw");
    core_req = 0;
    @(negedge clk); #1;
    chk("b2b idle_req", 32'(mem.req), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
